// File: rtl/jk_bank_driver.sv
// -----------------------------------------------------------------------------
// jk_bank_driver
//
// Excitation-side controller for a bank of WIDTH JK flip-flops. A target word
// is accepted over a valid/ready handshake. The block computes per-bit J/K
// excitation from the bank's current state (q_fb) and drives it for exactly
// one clock. It then checks the readback and reports done on a match. On a
// mismatch it retries up to MAX_RETRY times and then reports err.
//
// Optional build macro:
//   JK_DRV_TOGGLE_EN  - when defined, changing bits use toggle encoding
//                       (J=K=1). When undefined, set/reset encoding is used
//                       and J=K=1 is never emitted.
//
// Parameters:
//   WIDTH      number of JK flops driven
//   MAX_RETRY  extra DRIVE/CHECK attempts after the first mismatch
//
// Ports:
//   clk        rising-edge clock, shared with the driven flop bank
//   rst_n      asynchronous active-low reset
//   tgt_valid  target word valid
//   tgt_data   requested next flop-bank value
//   tgt_ready  high only in IDLE; a target is accepted when valid & ready
//   q_fb       q outputs of the driven flop bank
//   j, k       registered J/K inputs to the flop bank
//   busy       high in DRIVE or CHECK
//   done       one-cycle pulse: readback matched target
//   err        one-cycle pulse: retries exhausted without a match
//   mism       q_fb ^ target captured at the failing CHECK, held until the
//              next accept
// -----------------------------------------------------------------------------
module jk_bank_driver #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] mism
);

  // Retry counter must be at least one bit wide even when MAX_RETRY is 0.
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] tgt_nxt;
  logic [RW-1:0]    retry_cnt;
  logic [RW-1:0]    retry_nxt;
  logic [WIDTH-1:0] j_nxt;
  logic [WIDTH-1:0] k_nxt;
  logic [WIDTH-1:0] mism_nxt;
  logic             done_nxt;
  logic             err_nxt;

  // Per-bit excitation that moves the bank from cur to want in one edge.
  // The result is packed as {J, K}.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] want);
    logic [WIDTH-1:0] jv;
    logic [WIDTH-1:0] kv;
`ifdef JK_DRV_TOGGLE_EN
    jv = cur ^ want;
    kv = cur ^ want;
`else
    jv = ~cur & want;
    kv = cur & ~want;
`endif
    return {jv, kv};
  endfunction

  assign tgt_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tgt_q     <= '0;
      retry_cnt <= '0;
      j         <= '0;
      k         <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      mism      <= '0;
    end else begin
      state     <= state_nxt;
      tgt_q     <= tgt_nxt;
      retry_cnt <= retry_nxt;
      j         <= j_nxt;
      k         <= k_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      mism      <= mism_nxt;
    end
  end

  // J/K default to zero, so any cycle that is not a DRIVE cycle leaves the
  // bank holding its value.
  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt_q;
    retry_nxt = retry_cnt;
    j_nxt     = '0;
    k_nxt     = '0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    mism_nxt  = mism;

    case (state)
      IDLE: begin
        if (tgt_valid) begin
          tgt_nxt        = tgt_data;
          retry_nxt      = '0;
          mism_nxt       = '0;
          {j_nxt, k_nxt} = excite(q_fb, tgt_data);
          state_nxt      = DRIVE;
        end
      end

      DRIVE: begin
        state_nxt = CHECK;
      end

      CHECK: begin
        if (q_fb == tgt_q) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (retry_cnt < RW'(MAX_RETRY)) begin
          // Re-excite from the bank's actual state, not the original one.
          retry_nxt      = retry_cnt + RW'(1);
          {j_nxt, k_nxt} = excite(q_fb, tgt_q);
          state_nxt      = DRIVE;
        end else begin
          err_nxt   = 1'b1;
          mism_nxt  = q_fb ^ tgt_q;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// -----------------------------------------------------------------------------
// tb_jk_bank_driver
//
// Self-checking bench for jk_bank_driver. A behavioural JK flop bank, with an
// optional stuck-at-0 mask, is driven by the DUT. Each transaction's outcome
// is predicted at the transaction level: the first excitation, whether the
// target is reachable, the completion latency, the final bank value and the
// mismatch word.
// -----------------------------------------------------------------------------
module tb_jk_bank_driver;

  localparam int WIDTH     = 8;
  localparam int MAX_RETRY = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tgt_valid;
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_ready;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] mism;

  logic [WIDTH-1:0] bank;
  logic [WIDTH-1:0] stuck;
  logic [WIDTH-1:0] preset_val;
  logic             preset_en;

  int checks = 0;
  int errors = 0;

  jk_bank_driver #(
    .WIDTH    (WIDTH),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tgt_valid(tgt_valid),
    .tgt_data (tgt_data),
    .tgt_ready(tgt_ready),
    .q_fb     (q_fb),
    .j        (j),
    .k        (k),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mism     (mism)
  );

  always #5 clk = ~clk;

  assign q_fb = bank;

  // Behavioural JK flop bank: Q+ = J&~Q | ~K&Q, with stuck bits forced low.
  always @(posedge clk) begin
    if (preset_en) bank <= preset_val & ~stuck;
    else           bank <= ((j & ~bank) | (~k & bank)) & ~stuck;
  end

  typedef struct {
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] stk;
    logic [WIDTH-1:0] ej;
    logic [WIDTH-1:0] ek;
    bit               eerr;
    logic [WIDTH-1:0] emism;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference excitation: for each bit, decide from the JK truth table what
  // must be applied so that the flop lands on the wanted value.
  function automatic void model_excite(input logic [WIDTH-1:0] cur,
                                       input logic [WIDTH-1:0] want,
                                       output logic [WIDTH-1:0] ej,
                                       output logic [WIDTH-1:0] ek);
    ej = '0;
    ek = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cur[i] != want[i]) begin
`ifdef JK_DRV_TOGGLE_EN
        ej[i] = 1'b1;
        ek[i] = 1'b1;
`else
        if (want[i]) ej[i] = 1'b1;
        else         ek[i] = 1'b1;
`endif
      end
    end
  endfunction

  task automatic preset(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] s);
    stuck      = s;
    preset_val = v;
    preset_en  = 1'b1;
    step();
    preset_en  = 1'b0;
  endtask

  // Accept one target and follow it to done/err within a bounded window.
  task automatic run_txn(input string name, input logic [WIDTH-1:0] tgt,
                         input logic [WIDTH-1:0] ej, input logic [WIDTH-1:0] ek,
                         input bit exp_err, input logic [WIDTH-1:0] exp_mism,
                         input logic [WIDTH-1:0] exp_bank);
    int  exp_lat;
    int  exp_drives;
    int  lat;
    int  drives;
    bit  finished;
    bit  got_done;
    bit  got_err;
    exp_lat    = exp_err ? 3 + 2 * MAX_RETRY : 3;
    exp_drives = ((ej | ek) != '0) ? (exp_err ? MAX_RETRY + 1 : 1) : 0;
    check({name, " ready_idle"}, tgt_ready, 1);
    tgt_valid = 1'b1;
    tgt_data  = tgt;
    step();
    tgt_valid = 1'b0;
    check({name, " drive_j"}, j, ej);
    check({name, " drive_k"}, k, ek);
    check({name, " drive_busy"}, busy, 1);
    check({name, " drive_ready"}, tgt_ready, 0);
    drives   = ((j | k) != '0) ? 1 : 0;
    finished = 1'b0;
    got_done = 1'b0;
    got_err  = 1'b0;
    lat      = 0;
    for (int c = 2; c <= exp_lat + 4 && !finished; c++) begin
      step();
      if ((j | k) != '0) drives++;
      check({name, " done_err_excl"}, done & err, 0);
      if (done || err) begin
        finished = 1'b1;
        lat      = c;
        got_done = done;
        got_err  = err;
      end
    end
    if (!finished) begin
      check({name, " timeout"}, 0, 1);
    end else begin
      check({name, " latency"}, lat, exp_lat);
      check({name, " err"}, got_err, exp_err);
      check({name, " done"}, got_done, !exp_err);
      check({name, " mism"}, mism, exp_mism);
      check({name, " bank"}, bank, exp_bank);
      check({name, " drives"}, drives, exp_drives);
      check({name, " ready_end"}, tgt_ready, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] tg;
    logic [WIDTH-1:0] sk;
    logic [WIDTH-1:0] ej;
    logic [WIDTH-1:0] ek;
    bit               eerr;
    int               stray;

    // q0, tgt, stuck, expected J, expected K, err, mism
`ifdef JK_DRV_TOGGLE_EN
    tbl[0] = '{8'h00, 8'hA5, 8'h00, 8'hA5, 8'hA5, 1'b0, 8'h00};
    tbl[1] = '{8'hF0, 8'h0F, 8'h00, 8'hFF, 8'hFF, 1'b0, 8'h00};
    tbl[2] = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 1'b1, 8'h08};
    tbl[3] = '{8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[4] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0, 8'h00};
    tbl[5] = '{8'h5A, 8'hA5, 8'h01, 8'hFF, 8'hFF, 1'b1, 8'h01};
`else
    tbl[0] = '{8'h00, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{8'hF0, 8'h0F, 8'h00, 8'h0F, 8'hF0, 1'b0, 8'h00};
    tbl[2] = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 1'b1, 8'h08};
    tbl[3] = '{8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[4] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 8'h00};
    tbl[5] = '{8'h5A, 8'hA5, 8'h01, 8'hA5, 8'h5A, 1'b1, 8'h01};
`endif

    // Reset for two cycles, then idle.
    rst_n      = 1'b0;
    tgt_valid  = 1'b0;
    tgt_data   = '0;
    stuck      = '0;
    preset_val = '0;
    preset_en  = 1'b1;
    step();
    step();
    check("rst ready", tgt_ready, 1);
    check("rst busy", busy, 0);
    check("rst jk", {j, k}, 0);
    rst_n     = 1'b1;
    preset_en = 1'b0;
    step();
    check("idle ready", tgt_ready, 1);
    check("idle j", j, 0);
    check("idle k", k, 0);
    check("idle busy", busy, 0);
    check("idle done_err", {done, err}, 0);
    check("idle mism", mism, 0);

    // Directed vector table.
    for (int v = 0; v < 6; v++) begin
      preset(tbl[v].q0, tbl[v].stk);
      run_txn($sformatf("vec%0d", v), tbl[v].tgt, tbl[v].ej, tbl[v].ek,
              tbl[v].eerr, tbl[v].emism, tbl[v].tgt & ~tbl[v].stk);
    end

    // Back-to-back with valid held high through the busy cycles.
    preset(8'h00, 8'h00);
    tgt_valid = 1'b1;
    tgt_data  = 8'h11;
    step();
    tgt_data = 8'h22;
    check("b2b busy1 ready", tgt_ready, 0);
    step();
    check("b2b busy2 ready", tgt_ready, 0);
    step();
    check("b2b first done", done, 1);
    check("b2b done ready", tgt_ready, 1);
    check("b2b first bank", bank, 8'h11);
    step();
    tgt_valid = 1'b0;
    model_excite(8'h11, 8'h22, ej, ek);
    check("b2b second busy", busy, 1);
    check("b2b second j", j, ej);
    check("b2b second k", k, ek);
    step();
    check("b2b check no done", done, 0);
    step();
    check("b2b second done", done, 1);
    check("b2b second bank", bank, 8'h22);
    step();
    check("b2b no re-accept", busy, 0);

    // Reset asserted during DRIVE aborts and leaves the bank untouched.
    preset(8'h00, 8'h00);
    tgt_valid = 1'b1;
    tgt_data  = 8'h0F;
    step();
    tgt_valid = 1'b0;
    check("midrst drive busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst j", j, 0);
    check("midrst k", k, 0);
    check("midrst busy", busy, 0);
    check("midrst ready", tgt_ready, 1);
    step();
    step();
    check("midrst bank held", bank, 8'h00);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (done || err || busy) stray++;
    end
    check("midrst no stray", stray, 0);
    model_excite(8'h00, 8'h0F, ej, ek);
    run_txn("midrst recover", 8'h0F, ej, ek, 1'b0, 8'h00, 8'h0F);

    // Randomized transactions against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      q0 = WIDTH'($urandom);
      tg = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) sk = WIDTH'(1 << $urandom_range(0, WIDTH - 1));
      else                           sk = '0;
      if (n % 7 == 0) tg = q0 & ~sk;
      preset(q0, sk);
      model_excite(q0 & ~sk, tg, ej, ek);
      eerr = ((tg & sk) != '0);
      run_txn($sformatf("rnd%0d", n), tg, ej, ek, eerr,
              eerr ? (tg & sk) : '0, tg & ~sk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Excitation-side controller for a bank of WIDTH JK flip-flops. It produces the j/k inputs those flops consume and reads their q outputs back.
- Accepts a target word over a valid/ready handshake. From the current flop state (q_fb) it computes per-bit J/K excitation, drives it for exactly one clock, then checks the readback.
- Reports done on a match. On a mismatch it retries a bounded number of times, then reports err.
- Sits between sequencing/control logic and any JK-flop register bank in the design.

Parameters:
- WIDTH, 8, number of JK flops driven; width of target, q_fb, j, k, mism.
- MAX_RETRY, 3, extra DRIVE/CHECK attempts allowed after the first mismatch (0 = no retry).

Ports:
- clk  input  1  rising-edge clock, shared with the driven flop bank.
- rst_n  input  1  asynchronous active-low reset.
- tgt_valid  input  1  target word valid.
- tgt_data  input  WIDTH  requested next flop-bank value.
- tgt_ready  output  1  block can accept a target (high only in IDLE).
- q_fb  input  WIDTH  q outputs of the driven flop bank.
- j  output  WIDTH  J inputs to the flop bank.
- k  output  WIDTH  K inputs to the flop bank.
- busy  output  1  high in DRIVE or CHECK.
- done  output  1  one-cycle pulse: readback matched target.
- err  output  1  one-cycle pulse: retries exhausted without a match.
- mism  output  WIDTH  q_fb XOR target captured at the failing CHECK; held until the next accept.

Behaviour:
- Reset (rst_n low, async), all outputs and state cleared:
  - state=IDLE, tgt_ready=1, j=0, k=0, busy=0, done=0, err=0, mism=0.
  - Internal target register=0, retry_cnt=0.
- A reset asserted mid-operation aborts immediately. Because j=k=0 is forced, the flop bank holds its value.
- States: IDLE, DRIVE, CHECK. The j, k, done, err and mism outputs are all registered.
- IDLE:
  - tgt_ready=1, j=k=0.
  - On a clock edge with tgt_valid=1: capture tgt_data, set retry_cnt=0, clear mism, load j/k from the excitation of (q_fb, tgt_data), go to DRIVE.
- Excitation per bit i, with current state c=q_fb[i] and target t:
  - c=0, t=0 → J=0, K=0.
  - c=0, t=1 → J=1, K=0.
  - c=1, t=0 → J=0, K=1.
  - c=1, t=1 → J=0, K=0.
  - J=K=1 is never emitted unless the optional feature is enabled.
- DRIVE (exactly one cycle):
  - j/k are stable for the whole cycle; the flops sample them at the closing edge.
  - At that edge j and k are cleared and the state goes to CHECK.
- CHECK (one cycle): compare q_fb with the captured target at the closing edge.
  - Match: done=1 for one cycle, go to IDLE.
  - Mismatch and retry_cnt<MAX_RETRY: retry_cnt++, reload j/k from the current q_fb, go to DRIVE.
  - Mismatch and retry_cnt==MAX_RETRY: err=1 for one cycle, mism=q_fb^target, go to IDLE.
- Latency: accept edge at cycle 0 → done high during cycle 3, i.e. 3 cycles after the accept edge with no retries. Each retry adds 2 cycles.
- done/err pulse cycles are IDLE cycles, so tgt_ready=1 in them. A new target may be accepted in the same cycle done is high (back-to-back throughput: one target per 3 cycles).
- Target equal to the current q_fb: DRIVE still runs with j=k=0; done comes at the normal latency.
- tgt_valid while busy is ignored (tgt_ready=0); the producer holds it until accepted.
- done and err are never high in the same cycle.

Optional Feature:
- Macro JK_DRV_TOGGLE_EN.
- Defined: changing bits use toggle encoding J=K=1 (0→1 and 1→0). Held bits keep J=K=0.
- Undefined: set/reset encoding exactly as in the table above; J=K=1 never appears.
- Handshake, latency and retry behaviour are identical in both builds.

Test Plan:
- Reset, then idle: rst_n low for 2 cycles then release → tgt_ready=1, j=k=0, busy=0, done=err=0, mism=0.
- Basic write: bank q=8'h00, tgt_data=8'hA5 accepted → during DRIVE j=8'hA5, k=8'h00; bank reads 8'hA5; done pulse 3 cycles after accept; err=0.
- Clear and toggle paths: q=8'hF0, target 8'h0F.
  - Default build → j=8'h0F, k=8'hF0.
  - With JK_DRV_TOGGLE_EN → j=k=8'hFF.
  - Both builds: done, bank=8'h0F.
- Stuck bit with retry exhaustion: model forces bank bit 3 to 0, MAX_RETRY=3, target 8'h08 → 4 DRIVE cycles, err pulse 9 cycles after accept, mism=8'h08, no done.
- Back-to-back and ignored valid: targets 8'h11 then 8'h22 with tgt_valid held high → second accepted in the done cycle of the first; tgt_valid during busy produces no accept; bank ends at 8'h22.
- Reset mid-operation: rst_n pulled low during DRIVE → j=k=0 immediately, state IDLE, no done/err; a new target after release completes normally.
